// File: rtl/serial_adder_pkg.sv
// serial_adder shared types: FSM state encoding and default width.
// Optional subtract mode is enabled with SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder with start/busy/done framing.
// SERIAL_ADDER_SUB_EN adds the sub request bit.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;

  modport master (
    output start, A, B, Cin, sub,
    input  busy, done, S, Cout, ovf
  );

  modport slave (
    input  start, A, B, Cin, sub,
    output busy, done, S, Cout, ovf
  );
`else
  modport master (
    output start, A, B, Cin,
    input  busy, done, S, Cout, ovf
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, S, Cout, ovf
  );
`endif

endinterface

// File: rtl/serial_adder_bit_cell.sv
// serial_bit_cell: combinational 1-bit full-adder slice.
// Used once per clock by serial_adder's RUN datapath.
module serial_bit_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the subtract (sub) mode.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic         clk,
  input logic         reset,
  serial_adder_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic             sum_bit;
  logic             cy_next;

  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as A + ~B + 1; Cin has no meaning then.
  assign b_load = bus.sub ? ~bus.B : bus.B;
  assign c_load = bus.sub ? 1'b1 : bus.Cin;
`else
  assign b_load = bus.B;
  assign c_load = bus.Cin;
`endif

  serial_bit_cell u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (sum_bit),
    .co (cy_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == RUN):  busy = 1'b1;
      (state_q == DONE): done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      carry  <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        a_sh  <= bus.A;
        b_sh  <= b_load;
        carry <= c_load;
        cnt   <= '0;
      end
    end else if (state_q == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= {sum_bit, s_sh[WIDTH-1:1]};
      carry <= cy_next;
      cnt   <= cnt + ONE;
      // carry still holds the carry into the MSB here
      if (cnt == LAST) begin
        s_q    <= {sum_bit, s_sh[WIDTH-1:1]};
        cout_q <= cy_next;
        ovf_q  <= carry ^ cy_next;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: arithmetic model + directed/random.
// Exercises subtract cases when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string nm, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: phase 0 idle, 1..W busy, W+1 done pulse.
  int phase = 0;
  bit armed = 1'b0;
  int cap_a, cap_b, cap_c;
  int m_s = 0, m_cout = 0, m_ovf = 0;

  function automatic int sval(int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      phase = 0;
      m_s = 0;
      m_cout = 0;
      m_ovf = 0;
      armed = 1'b1;
    end else if (phase == 0) begin
      if (bus.start === 1'b1) begin
        cap_a = int'(bus.A);
        cap_b = int'(bus.B);
        cap_c = int'(bus.Cin);
`ifdef SERIAL_ADDER_SUB_EN
        if (bus.sub === 1'b1) begin
          cap_b = (~cap_b) & ((1 << W) - 1);
          cap_c = 1;
        end
`endif
        phase = 1;
      end
    end else if (phase <= W) begin
      if (phase == W) begin
        int tot, ssum;
        tot = cap_a + cap_b + cap_c;
        ssum = sval(cap_a) + sval(cap_b) + cap_c;
        m_s = tot % (1 << W);
        m_cout = tot >> W;
        m_ovf = (ssum >= (1 << (W - 1))) ||
                (ssum < -(1 << (W - 1)));
      end
      phase++;
    end else begin
      phase = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (armed) begin
      check("busy", int'(bus.busy), int'(phase >= 1 && phase <= W));
      check("done", int'(bus.done), int'(phase == W + 1));
      check("S", int'(bus.S), m_s);
      check("Cout", int'(bus.Cout), m_cout);
      check("ovf", int'(bus.ovf), m_ovf);
    end
  end

  task automatic set_ops(int a, int b, int c, int sb);
    bus.A = W'(a);
    bus.B = W'(b);
    bus.Cin = c[0];
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = sb[0];
`else
    if (sb != 0) $display("note: sub ignored in add-only build");
`endif
  endtask

  task automatic run_op(int a, int b, int c, int sb,
                        int es, int ec, int eo,
                        bit mid, int prev);
    int cyc, busy_n;
    @(negedge clk);
    set_ops(a, b, c, sb);
    bus.start = 1'b1;
    cyc = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      if (bus.busy) busy_n++;
      if (mid && cyc == 2) set_ops(8'h11, 8'h11, 0, 0);
      if (mid && cyc == 8) check("hold_S", int'(bus.S), prev);
    end while (!bus.done && cyc < 40);
    check("latency", cyc, W + 1);
    check("busy_len", busy_n, W);
    check("lit_S", int'(bus.S), es);
    check("lit_Cout", int'(bus.Cout), ec);
    check("lit_ovf", int'(bus.ovf), eo);
  endtask

  initial begin
    int dn;
    bus.start = 1'b0;
    set_ops(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_S", int'(bus.S), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);

    run_op(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1'b0, 0);
    run_op(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 1'b0, 0);
    run_op(8'hA5, 8'h5A, 1, 0, 8'h00, 1, 0, 1'b1, 8'h80);
`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 0, 1, 8'hFE, 0, 0, 1'b0, 0);
    run_op(8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, 1'b0, 0);
    set_ops(0, 0, 0, 0);
`endif

    // Held start: accepts only once per W+2 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    dn = 0;
    for (int i = 0; i < 2 * (W + 2); i++) begin
      @(negedge clk);
      if (bus.done) dn++;
      set_ops($urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 1), 0);
    end
    bus.start = 1'b0;
    check("held_dones", dn, 2);

    // Reset during the third RUN cycle aborts with no done.
    @(negedge clk);
    set_ops(8'h33, 8'h44, 1, 0);
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_S", int'(bus.S), 0);
    check("abort_Cout", int'(bus.Cout), 0);
    check("abort_ovf", int'(bus.ovf), 0);
    run_op(8'h33, 8'h44, 1, 0, 8'h78, 0, 0, 1'b0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      set_ops($urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 1), $urandom_range(0, 1));
    end
    bus.start = 1'b0;
    reset = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial adder, the sequential successor to the team's single-bit full adder. It adds two WIDTH-bit operands plus a carry-in, processing one bit per clock through a single registered carry. A start/busy/done handshake frames each operation. It is the reusable low-area arithmetic unit for multi-cycle datapaths.

Parameters:
WIDTH, 8, operand and sum width in bits (>=2).
CNT_W, $clog2(WIDTH)+1, bit-counter width (localparam, derived).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
A  input  WIDTH  operand A; captured on the accepted start
B  input  WIDTH  operand B; captured on the accepted start
Cin  input  1  carry-in; captured on the accepted start
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse; result valid
S  output  WIDTH  registered sum; holds last result until next completion
Cout  output  1  registered carry-out of the MSB
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset is synchronous, active-high, one clock, and takes priority over everything. It forces state=IDLE and counter=0, clears the shift registers and carry FF, and sets busy=0, done=0, S=0, Cout=0, ovf=0. Asserting reset mid-RUN aborts the operation with no done pulse.
- States:
  - IDLE: busy=0, done=0. On an edge with start=1: load a_sh<=A, b_sh<=B, carry<=Cin, cnt<=0; go to RUN. With start=0, stay in IDLE.
  - RUN: busy=1. On each edge:
    - sum bit = a_sh[0]^b_sh[0]^carry; carry <= majority(a_sh[0], b_sh[0], carry).
    - Shift a_sh and b_sh right; shift the sum bit into s_sh at the MSB.
    - cnt++.
    - On the edge where cnt==WIDTH-1: load S<={sum,s_sh[WIDTH-1:1]}, Cout<=new carry, ovf<=carry_in_to_MSB^new carry; go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- start is ignored while busy; a held start does not queue a request.
- Latency: start is accepted at edge k and done is high in the cycle after edge k+WIDTH, so the result is available WIDTH+1 cycles after the start cycle. Back-to-back throughput is one operation per WIDTH+2 cycles.
- S, Cout and ovf change only on the final RUN edge (or on reset). They never show partial results.
- Arithmetic is modulo 2^WIDTH: {Cout,S} = A+B+Cin exactly.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined: adds input port sub (1 bit), captured with the operands on the accepted start. When sub=1, b_sh loads ~B, Cin is ignored and carry loads 1, giving S=A-B. In this mode Cout=1 means no borrow, and ovf is signed subtraction overflow. When sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; add-only.

Decomposition:
- Package serial_adder_pkg holds:
  - the state typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the default-width constant.
- One natural sub-module: serial_bit_cell, a combinational 1-bit sum/carry slice instantiated once inside the RUN datapath.

Test Plan:
- WIDTH=8; A=0x00, B=0x00, Cin=0, start pulse -> done exactly 9 cycles after the start cycle; S=0x00, Cout=0, ovf=0; busy high for exactly 8 cycles.
- A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1, ovf=0. Then A=0x7F, B=0x01, Cin=0 -> S=0x80, Cout=0, ovf=1.
- A=0xA5, B=0x5A, Cin=1 -> S=0x00, Cout=1, ovf=0. Change A/B mid-RUN to 0x11 -> result unaffected, and S still holds the previous result until the final edge.
- Assert start every cycle while busy -> exactly one done per WIDTH+2 cycles; no extra operations; the second op uses the operands present at its own accepted start.
- reset on the 3rd RUN cycle -> next cycle all outputs 0, state IDLE, no done pulse. A fresh start then completes normally.
- With SERIAL_ADDER_SUB_EN: sub=1, A=0x05, B=0x07 -> S=0xFE, Cout=0. Then sub=1, A=0x80, B=0x01 -> S=0x7F, ovf=1.
